// File: rtl/truth_table_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into a combinational DUT and counts f/g responses that differ from EXP_F/EXP_G.
// Optional feature macro: STOP_ON_ERR_EN ends the sweep on the first mismatching vector.
module truth_table_checker #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [15:0] EXP_F       = 16'hF000,
    parameter logic [15:0] EXP_G       = 16'h6666
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_idx
);

`ifdef STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] idx_r, idx_s;
    logic [7:0] hold_r, hold_s;
    logic [4:0] err_r, err_s;
    logic [3:0] first_r, first_s;
    logic [3:0] vec_r;
    logic       busy_r, done_r, pass_r;
    logic       mismatch_s, last_hold_s;

    // Error counter never wraps: it stops at the 16-vector maximum.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        if (v >= 5'd16) begin
            return 5'd16;
        end else begin
            return v + 5'd1;
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, vector stepping and compare logic.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        hold_s      = hold_r;
        err_s       = err_r;
        first_s     = first_r;
        last_hold_s = (hold_r == HOLD_LAST);
        mismatch_s  = (f != EXP_F[idx_r]) || (g != EXP_G[idx_r]);
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = DRIVE;
                    idx_s   = 4'd0;
                    hold_s  = 8'd0;
                    err_s   = 5'd0;
                    first_s = 4'd0;
                end else begin
                    state_s = state_r;
                end
            end
            DRIVE: begin
                if (!last_hold_s) begin
                    hold_s = hold_r + 8'd1;
                end else if (STOP_ON_ERR && mismatch_s) begin
                    err_s   = 5'd1;
                    first_s = idx_r;
                    state_s = DONE;
                end else begin
                    if (mismatch_s) begin
                        err_s   = sat_inc(err_r);
                        first_s = (err_r == 5'd0) ? idx_r : first_r;
                    end else begin
                        err_s   = err_r;
                    end
                    if (idx_r == 4'd15) begin
                        state_s = DONE;
                    end else begin
                        idx_s  = idx_r + 4'd1;
                        hold_s = 8'd0;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath and status registers; outputs are decoded from next-state so they change with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= 4'd0;
            hold_r  <= 8'd0;
            err_r   <= 5'd0;
            first_r <= 4'd0;
            vec_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            idx_r   <= idx_s;
            hold_r  <= hold_s;
            err_r   <= err_s;
            first_r <= first_s;
            vec_r   <= (state_s == DRIVE) ? idx_s : 4'd0;
            busy_r  <= (state_s == DRIVE);
            done_r  <= (state_s == DONE);
            pass_r  <= (state_s == DONE) && (err_s == 5'd0);
        end
    end

    assign {a, b, c, d}  = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = first_r;

endmodule
